// File: rtl/dco_freq_counter_if.sv
// dco_freq_counter_if: valid/ready result port carrying the edge count and overflow flag
interface dco_freq_counter_if #(parameter int CNT_W = 16);
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             valid;
  logic             ready;
  modport master (output count, overflow, valid, input ready);
  modport slave  (input count, overflow, valid, output ready);
endinterface

// File: rtl/dco_freq_counter.sv
// dco_freq_counter: synchronises dco_in and counts its rising edges over a fixed clk gate window
module dco_freq_counter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dco_in,
  input  logic                 start,
  input  logic                 continuous,
  output logic                 busy,
  dco_freq_counter_if.master   res
);
  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, OUT} state_t;
  localparam int GW = $clog2(GATE_CYCLES + SYNC_STAGES);
  localparam logic [GW-1:0] G_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0] S_LAST = GW'(SYNC_STAGES - 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dco_p;
  logic [GW-1:0]          r_gate;
  logic [CNT_W-1:0]       r_edges;
  logic                   r_flag;
  logic [CNT_W-1:0]       r_count;
  logic                   r_ovf;
  logic                   r_valid;
  logic                   r_busy;
  logic                   w_dco_s;
  logic                   w_edge;
  logic                   w_sat;
  logic [CNT_W-1:0]       w_edges_nx;
  logic                   w_flag_nx;
  assign w_dco_s    = r_sync[SYNC_STAGES-1];
  assign w_edge     = w_dco_s & ~r_dco_p;
  assign w_sat      = r_edges == MAX;
  // an edge arriving at full scale is lost, so it is what marks the result as saturated
  assign w_edges_nx = r_edges + CNT_W'(w_edge & ~w_sat);
  assign w_flag_nx  = r_flag | (w_edge & w_sat);
  assign busy         = r_busy;
  assign res.count    = r_count;
  assign res.overflow = r_ovf;
  assign res.valid    = r_valid;
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_sync  <= '0;
      r_dco_p <= 1'b0;
      r_gate  <= '0;
      r_edges <= '0;
      r_flag  <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], dco_in};
      r_dco_p <= w_dco_s;
      case (r_state)
        IDLE: if (start | continuous) begin
          r_state <= SETTLE;
          r_busy  <= 1'b1;
          r_gate  <= '0;
        end
        SETTLE: if (r_gate == S_LAST) begin
          r_state <= COUNT;
          r_gate  <= '0;
          r_edges <= '0;
          r_flag  <= 1'b0;
        end else r_gate <= r_gate + GW'(1);
        COUNT: begin
          r_edges <= w_edges_nx;
          r_flag  <= w_flag_nx;
          r_gate  <= r_gate + GW'(1);
          if (r_gate == G_LAST) begin
            r_state <= OUT;
            r_count <= w_edges_nx;
            r_ovf   <= w_flag_nx;
            r_valid <= 1'b1;
          end
        end
        OUT: if (res.ready) begin
          r_valid <= 1'b0;
          r_busy  <= continuous;
          r_state <= continuous ? SETTLE : IDLE;
          r_gate  <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dco_freq_counter.md
Name: dco_freq_counter

Overview:
Downstream measurement stage for the DCO macro. It takes the DCO output (`dco_in`), which is asynchronous to `clk`, and synchronises it. It then counts rising edges over a fixed gate window of `GATE_CYCLES` system-clock cycles and presents the count through a valid/ready result port. It lets the DCO-code sweep (one 8-bit code per step) be characterised on chip. It is also the frequency-error source for a later code-tuning loop.

Parameters:
- GATE_CYCLES, 1000: gate window length in `clk` cycles; must be ≥ 2.
- CNT_W, 16: width of the edge counter and of the result.
- SYNC_STAGES, 2: flip-flop depth of the `dco_in` synchroniser; must be ≥ 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous and active-high (1 = reset), sampled on the `clk` rising edge.
- dco_in  in  1  raw DCO output, asynchronous to `clk`.
- start  in  1  single-cycle request for one measurement; honoured only in IDLE.
- continuous  in  1  when 1, measurements repeat back-to-back.
- ready  in  1  consumer accepts the result.
- count  out  CNT_W  measured rising-edge count.
- overflow  out  1  edge counter saturated during the window.
- valid  out  1  `count`/`overflow` hold a result.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset, while `rst_n` = 1 at a `clk` edge:
  - state goes to IDLE; synchroniser and edge-detect flops go to 0;
  - `count` = 0, `overflow` = 0, `valid` = 0, `busy` = 0;
  - gate and edge counters go to 0.
  - Reset asserted mid-measurement aborts it; no result is produced.
- Synchroniser: chain of `SYNC_STAGES` flops. `dco_s` is the last stage; `dco_p` is `dco_s` delayed by one cycle.
- Edge event: `edge` = `dco_s` & ~`dco_p`. Accuracy requires f_dco < f_clk/2; above that, edges alias and no error is flagged.
- States:
  - IDLE: if `start` or `continuous` is 1, go to SETTLE.
  - SETTLE: lasts `SYNC_STAGES` cycles and ignores edges. On exit, the gate counter and edge counter go to 0, then go to COUNT.
  - COUNT: lasts exactly `GATE_CYCLES` cycles.
    - Each cycle with `edge` = 1 increments the edge counter.
    - At 2^CNT_W−1 the counter holds and sets an internal overflow flag.
    - An edge in the final gate cycle is counted.
    - After the final cycle, `count` ← edge counter, `overflow` ← flag, `valid` ← 1, go to OUT.
  - OUT: `count`/`overflow` are held stable while `valid` = 1; edges are ignored.
    - In a cycle with `valid` & `ready`, `valid` clears on the next edge.
    - Next state is SETTLE if `continuous` = 1 in that cycle, else IDLE.
    - `count` keeps its last value after `valid` clears.
- Latency: `start` sampled at edge T0 → COUNT covers T0+S+1 .. T0+S+G → `valid` high from T0+S+G+1 (S = `SYNC_STAGES`, G = `GATE_CYCLES`).
- Input priority and edge cases:
  - `start` while `busy` = 1 is ignored.
  - `start` and `continuous` both high in IDLE give a single entry to SETTLE.
  - `continuous` dropped mid-COUNT: the current measurement completes and is delivered; the block then returns to IDLE after the handshake.
  - `ready` high with `valid` = 0 has no effect.
  - `ready` held high continuously: `valid` is high for exactly one cycle per result.
  - Backpressure (`ready` = 0) stalls indefinitely in OUT; no measurement is lost or overwritten.
  - Static `dco_in` (0 or 1) gives `count` = 0, `overflow` = 0.
  - Gate and edge counters wrap only via reset/restart, never mid-window.

Test Plan:
Common setup: `clk` period 20 ns, GATE_CYCLES = 100, SYNC_STAGES = 2, CNT_W = 16 unless stated.
1. Reset = 1 for 3 cycles, then 0 → `count` = 0, `valid` = 0, `busy` = 0, `overflow` = 0. Pulse `start` at T0 → `busy` = 1 at T0+1; `valid` rises at T0+103.
2. `dco_in` period 100 ns (5 `clk` cycles, synchronous source) → `count` = 20, `overflow` = 0. Period 40 ns → `count` = 50. `dco_in` held 0 → `count` = 0.
3. CNT_W = 4, `dco_in` period 80 ns (25 edges) → `count` = 15, `overflow` = 1.
4. `ready` = 0 for 50 cycles after `valid` → `valid` stays 1 and `count` = 20 unchanged; `start` pulses during this time are ignored. `ready` = 1 for one cycle → `valid` = 0 next cycle, `busy` = 0.
5. `continuous` = 1, `ready` = 1, `dco_in` period 100 ns → `valid` pulses every 103 cycles, each with `count` = 20. Drop `continuous` mid-COUNT → exactly one further result, then IDLE.
6. Assert reset mid-COUNT (cycle 50) → next cycle `busy` = 0, `valid` = 0, `count` = 0. A new `start` → full result `count` = 20.
